// File: rtl/avalon_copy_master_if.sv
// Avalon-MM bus bundle between the copy engine (master) and the interconnect (slave).
interface avalon_copy_master_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic              read;
    logic              write;
    logic [3:0]        byte_en;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              waitrequest;
    logic              readdatavalid;

    modport master (
        output addr, read, write, byte_en, writedata,
        input  readdata, waitrequest, readdatavalid
    );

    modport slave (
        input  addr, read, write, byte_en, writedata,
        output readdata, waitrequest, readdatavalid
    );
endinterface

// File: rtl/avalon_copy_master.sv
// Avalon-MM master copying WORD_COUNT 32-bit words from src to dst, one read then one write per word.
module avalon_copy_master #(
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    src_addr,
    input  logic [ADDR_W-1:0]    dst_addr,
    input  logic [CNT_W-1:0]     word_count,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    avalon_copy_master_if.master avm
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, FIN} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [CNT_W-1:0]  remaining;
    logic [31:0]       data_reg;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;
    logic              abort;

    assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Completing a handshake takes priority over a timeout landing in the same cycle.
    always_comb begin
        state_next    = state;
        abort         = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        avm.read      = 1'b0;
        avm.write     = 1'b0;
        avm.addr      = '0;
        avm.byte_en   = 4'b0000;
        avm.writedata = data_reg;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (word_count == '0) ? FIN : RD_REQ;
                end
            end
            RD_REQ: begin
                busy        = 1'b1;
                avm.read    = 1'b1;
                avm.addr    = src_ptr;
                avm.byte_en = 4'b1111;
                if (!avm.waitrequest) begin
                    state_next = RD_WAIT;
                end else if (timeout_hit) begin
                    state_next = FIN;
                    abort      = 1'b1;
                end
            end
            RD_WAIT: begin
                busy = 1'b1;
                if (avm.readdatavalid) begin
                    state_next = WR_REQ;
                end else if (timeout_hit) begin
                    state_next = FIN;
                    abort      = 1'b1;
                end
            end
            WR_REQ: begin
                busy        = 1'b1;
                avm.write   = 1'b1;
                avm.addr    = dst_ptr;
                avm.byte_en = 4'b1111;
                if (!avm.waitrequest) begin
                    state_next = (remaining == CNT_W'(1)) ? FIN : RD_REQ;
                end else if (timeout_hit) begin
                    state_next = FIN;
                    abort      = 1'b1;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The wait counter restarts whenever the state changes, so each wait state gets its own budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            data_reg  <= '0;
            wait_cnt  <= '0;
            error     <= 1'b0;
        end else begin
            if (state_next != state || !busy) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (abort) begin
                error <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr   <= src_addr & ~ADDR_W'(3);
                        dst_ptr   <= dst_addr & ~ADDR_W'(3);
                        remaining <= word_count;
                        error     <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (avm.readdatavalid) begin
                        data_reg <= avm.readdata;
                    end
                end
                WR_REQ: begin
                    if (!avm.waitrequest) begin
                        src_ptr   <= src_ptr + ADDR_W'(4);
                        dst_ptr   <= dst_ptr + ADDR_W'(4);
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_avalon_copy_master.sv
// Randomized bench for avalon_copy_master: behavioural memory slave plus a word-by-word copy model.
`timescale 1ns/1ps
module tb_avalon_copy_master;
    localparam int ADDR_W  = 32;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [CNT_W-1:0]  word_count;
    logic              busy;
    logic              done;
    logic              error;

    avalon_copy_master_if #(.ADDR_W(ADDR_W)) avm ();

    avalon_copy_master #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .avm        (avm)
    );

    always #10 clk = ~clk;

    int num_compared   = 0;
    int num_mismatched = 0;

    logic [31:0] mem  [logic [31:0]];
    logic [31:0] mmem [logic [31:0]];
    int          rd_stall_q[$];
    int          wr_stall_q[$];
    int          lat_q[$];
    logic [31:0] rd_log[$];
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    int          read_cycles;
    int          write_cycles;
    int          viol_cnt;
    bit          never_valid;
    bit          stray_valid;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_compared++;
        if (observed !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] backing(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return backing(a);
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        if (mmem.exists(a)) return mmem[a];
        return backing(a);
    endfunction

    // Memory slave: per-request stall and read latency come from the queues the test fills.
    initial begin : slave
        logic        p_read, p_write, p_wait;
        logic [31:0] p_addr, p_wdata, pend_addr;
        logic [3:0]  p_be;
        int          stall_target, stall_cnt, lat_left;
        bit          in_req;
        p_read = 0; p_write = 0; p_wait = 0; p_addr = 0; p_wdata = 0; p_be = 0;
        pend_addr = 0; stall_target = 0; stall_cnt = 0; lat_left = 0; in_req = 0;
        avm.waitrequest = 1'b0; avm.readdatavalid = 1'b0; avm.readdata = '0;
        read_cycles = 0; write_cycles = 0; viol_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                p_read = 0; p_write = 0; p_wait = 0; in_req = 0; lat_left = 0;
                avm.waitrequest = 1'b0; avm.readdatavalid = 1'b0;
            end else begin
                if (p_read && !p_wait) begin
                    lat_left  = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
                    pend_addr = p_addr;
                end
                if (p_write && !p_wait) begin
                    wr_addr_log.push_back(p_addr);
                    wr_data_log.push_back(p_wdata);
                    mem[p_addr] = p_wdata;
                end
                avm.readdatavalid = 1'b0;
                avm.readdata      = $urandom();
                if (lat_left > 0) begin
                    lat_left--;
                    if (lat_left == 0 && !never_valid) begin
                        avm.readdatavalid = 1'b1;
                        avm.readdata      = memRead(pend_addr);
                    end
                end
                if (stray_valid) begin
                    avm.readdatavalid = 1'b1;
                    stray_valid       = 1'b0;
                end
                if (p_wait && (p_read || p_write) && (avm.read || avm.write)) begin
                    if (avm.addr !== p_addr || avm.read !== p_read || avm.write !== p_write ||
                        avm.writedata !== p_wdata || avm.byte_en !== p_be) viol_cnt++;
                end
                if (avm.read && avm.write) viol_cnt++;
                if (avm.byte_en !== ((avm.read || avm.write) ? 4'b1111 : 4'b0000)) viol_cnt++;
                if (avm.read)  read_cycles++;
                if (avm.write) write_cycles++;
                if (avm.read || avm.write) begin
                    if (!in_req) begin
                        in_req    = 1;
                        stall_cnt = 0;
                        if (avm.read) begin
                            stall_target = (rd_stall_q.size() > 0) ? rd_stall_q.pop_front() : 0;
                            rd_log.push_back(avm.addr);
                        end else begin
                            stall_target = (wr_stall_q.size() > 0) ? wr_stall_q.pop_front() : 0;
                        end
                    end
                    if (stall_cnt < stall_target) begin
                        avm.waitrequest = 1'b1;
                        stall_cnt++;
                    end else begin
                        avm.waitrequest = 1'b0;
                        in_req          = 0;
                    end
                end else begin
                    avm.waitrequest = 1'($urandom_range(1, 0));
                    in_req          = 0;
                end
                p_read = avm.read; p_write = avm.write; p_wait = avm.waitrequest;
                p_addr = avm.addr; p_wdata = avm.writedata; p_be = avm.byte_en;
            end
        end
    end

    task automatic startCopy(input logic [31:0] src, input logic [31:0] dst, input int n);
        @(negedge clk);
        rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
        read_cycles = 0; write_cycles = 0; viol_cnt = 0;
        src_addr = src; dst_addr = dst; word_count = CNT_W'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        src_addr = $urandom(); dst_addr = $urandom(); word_count = CNT_W'($urandom());
    endtask

    task automatic waitDone(input int poke_cyc, output int done_cyc, output logic err_at_done, output bit busy_seen);
        done_cyc = -1; err_at_done = 1'b0; busy_seen = 0;
        for (int cyc = 1; cyc <= 1000; cyc++) begin
            @(negedge clk);
            start = (cyc == poke_cyc);
            if (cyc == 1) checkOutput("err_clear_on_start", {31'b0, error}, 32'd0);
            if (busy) busy_seen = 1;
            if (done) begin
                done_cyc    = cyc;
                err_at_done = error;
                break;
            end
        end
        if (done_cyc < 0) begin
            start = 1'b0;
            checkOutput("done_within_budget", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
            start = 1'b0;
            checkOutput("done_one_cycle", {31'b0, done}, 32'd0);
            checkOutput("idle_after_done", {31'b0, busy}, 32'd0);
        end
    endtask

    // Expected traffic comes from copying the model memory word by word; expected latency from the per-word delays.
    task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input int n,
                                 input int smin, input int smax, input int lmin, input int lmax);
        logic [31:0] exp_rd[$];
        logic [31:0] exp_wa[$];
        logic [31:0] exp_wd[$];
        logic [31:0] s, d, w;
        int          exp_cyc, done_cyc, rs, ws, lt;
        logic        err;
        bit          bs;
        rd_stall_q.delete(); wr_stall_q.delete(); lat_q.delete();
        mem.delete(); mmem.delete();
        s = src & ~32'h3;
        d = dst & ~32'h3;
        exp_cyc = 1;
        for (int i = 0; i < n; i++) begin
            rs = int'($urandom_range(smax, smin));
            ws = int'($urandom_range(smax, smin));
            lt = int'($urandom_range(lmax, lmin));
            rd_stall_q.push_back(rs); wr_stall_q.push_back(ws); lat_q.push_back(lt);
            exp_cyc += (rs + 1) + lt + (ws + 1);
            w = modelRead(s);
            mmem[d] = w;
            exp_rd.push_back(s); exp_wa.push_back(d); exp_wd.push_back(w);
            s += 32'd4;
            d += 32'd4;
        end
        startCopy(src, dst, n);
        waitDone((n > 0) ? 2 : 1, done_cyc, err, bs);
        checkOutput("done_cycle", done_cyc, exp_cyc);
        checkOutput("error_at_done", {31'b0, err}, 32'd0);
        checkOutput("busy_seen", {31'b0, bs}, (n > 0) ? 32'd1 : 32'd0);
        checkOutput("read_count", rd_log.size(), n);
        checkOutput("write_count", wr_addr_log.size(), n);
        for (int i = 0; i < n && i < rd_log.size(); i++) checkOutput("read_addr", rd_log[i], exp_rd[i]);
        for (int i = 0; i < n && i < wr_addr_log.size(); i++) begin
            checkOutput("write_addr", wr_addr_log[i], exp_wa[i]);
            checkOutput("write_data", wr_data_log[i], exp_wd[i]);
        end
        checkOutput("bus_rules", viol_cnt, 32'd0);
        if (n == 0) checkOutput("no_bus_cycles", read_cycles + write_cycles, 32'd0);
    endtask

    initial begin
        int   done_cyc;
        logic err;
        bit   bs;
        int   idle_bad;
        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; word_count = '0;
        never_valid = 0; stray_valid = 0;
        #5;
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_error", {31'b0, error}, 32'd0);
        checkOutput("rst_rw", {30'b0, avm.read, avm.write}, 32'd0);
        checkOutput("rst_addr", avm.addr, 32'd0);
        checkOutput("rst_wdata", avm.writedata, 32'd0);
        checkOutput("rst_be", {28'b0, avm.byte_en}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed copies");
        applyStimulus(32'h0000_0100, 32'h0000_0200, 4, 0, 0, 1, 1);
        applyStimulus(32'h0000_0100, 32'h0000_0200, 0, 0, 0, 1, 1);
        applyStimulus(32'h0000_1000, 32'h0000_2000, 2, 3, 3, 2, 2);
        applyStimulus(32'hFFFF_FFFC, 32'h0000_0503, 2, 0, 1, 1, 2);

        $display("[TB] timeout waiting for read data");
        rd_stall_q.delete(); wr_stall_q.delete(); lat_q.delete();
        never_valid = 1;
        startCopy(32'h0000_0040, 32'h0000_0080, 1);
        waitDone(2, done_cyc, err, bs);
        never_valid = 0;
        checkOutput("rdwait_timeout_cycle", done_cyc, 32'd18);
        checkOutput("rdwait_timeout_error", {31'b0, err}, 32'd1);
        checkOutput("rdwait_read_cycles", read_cycles, 32'd1);
        checkOutput("rdwait_no_write", wr_addr_log.size(), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("error_sticky", {31'b0, error}, 32'd1);
        applyStimulus($urandom(), $urandom(), 3, 0, 2, 1, 3);

        $display("[TB] timeout on a stalled read request");
        rd_stall_q.delete(); wr_stall_q.delete(); lat_q.delete();
        rd_stall_q.push_back(1000);
        startCopy(32'h0000_0600, 32'h0000_0700, 3);
        waitDone(2, done_cyc, err, bs);
        checkOutput("rdreq_timeout_cycle", done_cyc, 32'd17);
        checkOutput("rdreq_timeout_error", {31'b0, err}, 32'd1);
        checkOutput("rdreq_read_cycles", read_cycles, 32'd16);

        $display("[TB] reset during second write");
        rd_stall_q.delete(); wr_stall_q.delete(); lat_q.delete();
        startCopy(32'h0000_0300, 32'h0000_0400, 4);
        repeat (6) @(negedge clk);
        checkOutput("pre_rst_write", {31'b0, avm.write}, 32'd1);
        checkOutput("pre_rst_addr", avm.addr, 32'h0000_0404);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("mid_rst_done", {31'b0, done}, 32'd0);
        checkOutput("mid_rst_error", {31'b0, error}, 32'd0);
        checkOutput("mid_rst_rw", {30'b0, avm.read, avm.write}, 32'd0);
        checkOutput("mid_rst_addr", avm.addr, 32'd0);
        checkOutput("mid_rst_wdata", avm.writedata, 32'd0);
        checkOutput("mid_rst_be", {28'b0, avm.byte_en}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stray_valid = 1;
        idle_bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (busy || done || avm.read || avm.write) idle_bad++;
        end
        checkOutput("post_rst_idle", idle_bad, 32'd0);
        applyStimulus(32'h0000_0300, 32'h0000_0400, 4, 0, 0, 1, 1);

        $display("[TB] randomized copies");
        for (int t = 0; t < 8; t++) begin
            applyStimulus($urandom(), $urandom(), int'($urandom_range(6, 0)), 0, 2, 1, 3);
        end
        applyStimulus(32'hFFFF_FFF0, 32'hFFFF_FFF4, 5, 0, 1, 1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end
endmodule
